// File: rtl/ihp_sram_pkg.sv
// ihp_sram_pkg: shared widths, FSM states and access-kind encoding for the SRAM macro emulator
package ihp_sram_pkg;
    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 32;
    typedef enum logic {ST_CLEAR, ST_READY} state_t;
    typedef enum logic [1:0] {ACC_NONE, ACC_RD, ACC_WR, ACC_RW} acc_t;
    function automatic acc_t acc_kind(input logic wen, input logic ren);
        return wen ? (ren ? ACC_RW : ACC_WR) : (ren ? ACC_RD : ACC_NONE);
    endfunction
endpackage

// File: rtl/ihp_sram_emu_array.sv
// ihp_sram_emu_array: single-port bit-masked storage with registered read-before-write output
module ihp_sram_emu_array
    import ihp_sram_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    input  logic [DATA_W-1:0] bm,
    output logic [DATA_W-1:0] dout
);
    logic [DATA_W-1:0] mem [2**ADDR_W];
    always_ff @(posedge clk)
        if (we) mem[addr] <= (mem[addr] & ~bm) | (din & bm);
    always_ff @(posedge clk)
        if (rst) dout <= '0;
        else if (re) dout <= mem[addr];
endmodule

// File: rtl/ihp_sram_macro_emu.sv
// ihp_sram_macro_emu: SRAM macro responder with post-reset clear, access qualification and sticky error flags
module ihp_sram_macro_emu
    import ihp_sram_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter bit INIT_CLEAR = 1'b1
) (
    input  logic              UserCLK,
    input  logic              reset,
    input  logic              CONFIGURED_top,
    input  logic [ADDR_W-1:0] A_ADDR_SRAM,
    input  logic [DATA_W-1:0] A_DIN_SRAM,
    input  logic [DATA_W-1:0] A_BM_SRAM,
    input  logic              A_MEN_SRAM,
    input  logic              A_WEN_SRAM,
    input  logic              A_REN_SRAM,
    output logic [DATA_W-1:0] A_DOUT_SRAM,
    output logic              ready,
    output logic              err_collision,
    output logic              err_dropped
);
    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic              live;
    logic              clr;
    acc_t              acc;
    always_comb begin
        live = ready & CONFIGURED_top;
        acc  = (A_MEN_SRAM & live & ~reset) ? acc_kind(A_WEN_SRAM, A_REN_SRAM) : ACC_NONE;
        clr  = (state == ST_CLEAR) & ~reset;
    end
    always_ff @(posedge UserCLK)
        if (reset) begin
            state         <= INIT_CLEAR ? ST_CLEAR : ST_READY;
            cnt           <= '0;
            ready         <= 1'b0;
            err_collision <= 1'b0;
            err_dropped   <= 1'b0;
        end else begin
            ready <= state == ST_READY;
            if (state == ST_CLEAR) begin
                cnt <= cnt + 1'b1;
                if (&cnt) state <= ST_READY;
            end
            if (acc == ACC_RW) err_collision <= 1'b1;
            if (A_MEN_SRAM & ~live) err_dropped <= 1'b1;
        end
    // the clear sequencer owns the array port until ready, so fabric accesses cannot race it
    ihp_sram_emu_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_array (
        .clk  (UserCLK),
        .rst  (reset),
        .we   (clr | acc == ACC_WR | acc == ACC_RW),
        .re   (acc == ACC_RD | acc == ACC_RW),
        .addr (clr ? cnt : A_ADDR_SRAM),
        .din  (clr ? '0 : A_DIN_SRAM),
        .bm   (clr ? '1 : A_BM_SRAM),
        .dout (A_DOUT_SRAM)
    );
endmodule

// File: doc/ihp_sram_macro_emu.md
# ihp_sram_macro_emu

Cycle-accurate, synthesizable responder for the SRAM macro port that the IHP_SRAM fabric tile pair drives. It implements the memory end of the A_ADDR/A_DIN/A_BM/A_WEN/A_MEN/A_REN → A_DOUT interface, so the fabric can be run and verified without the hard macro:
- under EMULATION builds;
- in fabric-level simulation.

A post-reset clear sequencer guarantees deterministic contents before the fabric may access the array.

## Interface
Parameters:
- ADDR_W, 10, address width; depth = 2**ADDR_W words
- DATA_W, 32, word and bit-mask width
- INIT_CLEAR, 1, 1 = zero the whole array after reset; 0 = ready immediately, contents undefined

Ports:
- UserCLK  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- CONFIGURED_top  in  1  fabric configured; accesses are ignored while low
- A_ADDR_SRAM  in  ADDR_W  word address
- A_DIN_SRAM  in  DATA_W  write data
- A_BM_SRAM  in  DATA_W  per-bit write mask; 1 = bit written
- A_MEN_SRAM  in  1  macro enable; qualifies WEN and REN
- A_WEN_SRAM  in  1  write enable
- A_REN_SRAM  in  1  read enable
- A_DOUT_SRAM  out  DATA_W  registered read data
- ready  out  1  clear sequence done; accesses honoured
- err_collision  out  1  sticky: WEN and REN were both asserted in one access
- err_dropped  out  1  sticky: MEN was asserted while ready=0 or CONFIGURED_top=0

## Operation
- An access is valid when A_MEN_SRAM & ready & CONFIGURED_top. Otherwise the array and A_DOUT_SRAM are untouched.
- If MEN is asserted while the access is not valid, err_dropped is set.
- States: ST_CLEAR and ST_READY.
  - Reset enters ST_CLEAR when INIT_CLEAR=1, else ST_READY.
  - ST_CLEAR: a clear counter starting at 0 writes zero to mem[cnt] each cycle.
  - When cnt = 2**ADDR_W−1 the last word is written and the FSM moves to ST_READY. The counter wraps to 0 and is then unused.
  - ST_READY has no exit except reset.
- ready = (state == ST_READY), registered.
- Write (valid & WEN): mem[A] ← (mem[A] & ~BM) | (DIN & BM). BM = 0 means no bits change, but it still counts as an access.
- Read (valid & REN & ~WEN): A_DOUT_SRAM ← mem[A] on the next edge.
- Collision (valid & WEN & REN):
  - the write is performed;
  - A_DOUT_SRAM ← the pre-write contents of mem[A] (read-before-write);
  - err_collision is set.
- A_DOUT_SRAM holds its last value in every cycle that has no read, including writes and idle cycles.
- The sticky error flags clear only on reset.
- A_ADDR_SRAM is always in range because the address has full width. No aliasing is performed.

## Timing
- Reset values: A_DOUT_SRAM = 0, err_collision = 0, err_dropped = 0, clear counter = 0.
  - ready = 0 when INIT_CLEAR=1.
  - ready = 1 when INIT_CLEAR=0; it goes high on the first edge with reset low.
- Clear duration: 2**ADDR_W cycles after the first edge with reset low. ready rises on the following edge: 1025 edges total for ADDR_W=10.
- Read latency: 1 cycle. Address and REN sampled at edge N give data on A_DOUT_SRAM after edge N. Reads are fully pipelined, one per cycle.
- Write-then-read at the same address on consecutive cycles returns the new data. There is no stale window.
- Reset asserted mid-clear: the counter returns to 0 and the clear restarts from word 0. Reset always takes priority over any access in the same cycle.
- CONFIGURED_top dropping mid-burst: accesses from that edge onward are ignored. Already-returned data stays on A_DOUT_SRAM.

## Structure
- Package ihp_sram_pkg holds:
  - default ADDR_W and DATA_W;
  - the state enum {ST_CLEAR, ST_READY};
  - the access-kind encoding {ACC_NONE, ACC_RD, ACC_WR, ACC_RW}, shared with bench checkers.
- Sub-module ihp_sram_emu_array holds the storage. It has one read/write port with the bit mask and read-before-write semantics, so a vendor RAM can be swapped in.
- The top level holds the FSM, clear counter, access qualification and error flags.

## Test plan
- Reset with INIT_CLEAR=1, ADDR_W=4 → ready stays low for 16 cycles and rises on the 17th edge. Reading addresses 0..15 afterwards returns 0x00000000.
- Write 0xDEADBEEF with BM=0xFFFFFFFF to address 5, then write 0x00000000 with BM=0x0000FFFF → a read of address 5 returns 0xDEAD0000 one cycle after REN.
- Collision at address 3 holding 0x11111111, with WEN=REN=1 and DIN=0x22222222 at full mask → A_DOUT_SRAM=0x11111111 and err_collision=1. The next read of address 3 returns 0x22222222.
- MEN=1 and WEN=1 while CONFIGURED_top=0 → the array is unchanged on readback and err_dropped=1. The same applies when MEN is asserted during ST_CLEAR.
- Reset asserted at clear count 7 → clearing restarts from 0. ready rises 2**ADDR_W+1 edges after reset is released, and a word pre-written before the reset reads back as 0.
- Back-to-back reads of addresses 0,1,2 after writing them with 0xA,0xB,0xC → A_DOUT_SRAM shows 0xA,0xB,0xC on three consecutive cycles. A_DOUT_SRAM then holds 0xC while idle.
